// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory controller.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package imem_pkg;

   // Controller FSM: IDLE after reset, LOAD while the image is written, RUN while fetching.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_RUN  = 2'd2
   } imem_state_e;

   // RV32I "addi x0, x0, 0" -- returned whenever a fetch faults.
   localparam logic [31:0] IMEM_NOP = 32'h0000_0013;

   // Number of bits needed to index DEPTH instruction words.
   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction word storage: one synchronous write port, one combinational read port.
// Latency: write visible on the read port after the writing clock edge; read is 0 cycles.
// Backpressure: none; the array is never reset, so contents survive controller reset.
module imem_array #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  logic [31:0]   wdata_i,
   input  logic [AW-1:0] raddr_i,
   output logic [31:0]   rdata_o
);

   // Words are stored exactly as presented, so byte 0 of a word is bits [7:0].
   logic [31:0] mem_q [DEPTH];

   // Single write port; deliberately no reset so a reload can keep untouched words.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_mem_ctrl.sv
// Instruction memory controller: load port fills the array, fetch port reads it back.
// Latency: 1 cycle from request acceptance to rsp_valid; one fetch per cycle when rsp_ready=1.
// Backpressure: rsp_ready=0 holds the response register and drops req_ready.
// Optional build macro IMEM_MISALIGN_TRAP_EN: fault on req_pc[1:0] != 0 instead of ignoring those bits.
module instr_mem_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned DEPTH    = 64,
   parameter int unsigned PC_W     = 32,
   parameter logic [31:0] NOP_WORD = IMEM_NOP
) (
   input  logic                        clk,
   input  logic                        reset_n,
   // load port
   input  logic                        ld_start,
   input  logic                        ld_valid,
   input  logic [idx_width(DEPTH)-1:0] ld_addr,
   input  logic [31:0]                 ld_data,
   input  logic                        ld_done,
   output logic                        ld_busy,
   output logic                        ld_err,
   output logic [idx_width(DEPTH):0]   ld_count,
   // fetch port
   input  logic                        req_valid,
   input  logic [PC_W-1:0]             req_pc,
   output logic                        req_ready,
   output logic                        rsp_valid,
   output logic [31:0]                 rsp_instr,
   output logic                        rsp_fault,
   input  logic                        rsp_ready
);

   localparam int unsigned AW       = idx_width(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_ONE  = (AW+1)'(1);

   imem_state_e state_q, state_d;
   logic [AW:0] cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        mem_we;

   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_instr_q, rsp_instr_d;
   logic        rsp_fault_q, rsp_fault_d;

   logic [PC_W-3:0] word_idx;
   logic [AW-1:0]   rd_addr;
   logic [31:0]     rd_data;
   logic            idx_oor;
   logic            misalign;
   logic            fetch_fault;
   logic            accept;

   // ---------------------------------------------------------------------
   // Fetch address decode
   // ---------------------------------------------------------------------
   assign word_idx = req_pc[PC_W-1:2];
   assign rd_addr  = word_idx[AW-1:0];
   assign idx_oor  = (word_idx >= (PC_W-2)'(DEPTH));

`ifdef IMEM_MISALIGN_TRAP_EN
   assign misalign = (req_pc[1:0] != 2'b00);
`else
   // Low PC bits are ignored: every request is treated as word-aligned.
   logic unused_pc_lsb;
   assign unused_pc_lsb = ^req_pc[1:0];
   assign misalign      = 1'b0;
`endif

   assign fetch_fault = idx_oor | misalign;

   imem_array #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_array (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (ld_addr),
      .wdata_i (ld_data),
      .raddr_i (rd_addr),
      .rdata_o (rd_data)
   );

   // ---------------------------------------------------------------------
   // Control FSM and load counter
   // ---------------------------------------------------------------------

   // Next state, load counter and overflow flag; a write in the ld_done cycle still lands.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      mem_we  = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ld_start) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         ST_LOAD: begin
            if (ld_valid) begin
               if (cnt_q == CNT_FULL) begin
                  err_d = 1'b1;
               end else begin
                  mem_we = 1'b1;
                  cnt_d  = cnt_q + CNT_ONE;
               end
            end
            if (ld_done) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // A reload waits until no response is outstanding; the source holds ld_start.
            if (ld_start && !rsp_valid_q) begin
               state_d = ST_LOAD;
               cnt_d   = '0;
               err_d   = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State register, counter and sticky error flag.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Fetch handshake and response register
   // ---------------------------------------------------------------------
   assign req_ready = (state_q == ST_RUN) && (!rsp_valid_q || rsp_ready);
   assign accept    = req_valid && req_ready;

   // Load a new response on acceptance, drain on rsp_ready, otherwise hold.
   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_instr_d = rsp_instr_q;
      rsp_fault_d = rsp_fault_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_fault_d = fetch_fault;
         rsp_instr_d = fetch_fault ? NOP_WORD : rd_data;
      end else if (rsp_ready) begin
         rsp_valid_d = 1'b0;
      end
   end

   // Response register; reset discards any pending response.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_instr_q <= NOP_WORD;
         rsp_fault_q <= 1'b0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_instr_q <= rsp_instr_d;
         rsp_fault_q <= rsp_fault_d;
      end
   end

   assign ld_busy   = (state_q == ST_LOAD);
   assign ld_err    = err_q;
   assign ld_count  = cnt_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_instr = rsp_instr_q;
   assign rsp_fault = rsp_fault_q;

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// Directed bench for instr_mem_ctrl with a fetch-response scoreboard.
// Latency: checks every response arrives the cycle after its request is accepted.
// Backpressure: exercises rsp_ready stalls and ld_start blocking while a response is pending.
module tb_instr_mem_ctrl;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned PC_W  = 32;
   localparam logic [31:0] NOP   = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset_n = 1'b1;
   logic        ld_start = 1'b0;
   logic        ld_valid = 1'b0;
   logic [5:0]  ld_addr = '0;
   logic [31:0] ld_data = '0;
   logic        ld_done = 1'b0;
   logic        ld_busy;
   logic        ld_err;
   logic [6:0]  ld_count;
   logic        req_valid = 1'b0;
   logic [31:0] req_pc = '0;
   logic        req_ready;
   logic        rsp_valid;
   logic [31:0] rsp_instr;
   logic        rsp_fault;
   logic        rsp_ready = 1'b0;

   instr_mem_ctrl #(
      .DEPTH    (DEPTH),
      .PC_W     (PC_W),
      .NOP_WORD (NOP)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .ld_start  (ld_start),
      .ld_valid  (ld_valid),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .ld_done   (ld_done),
      .ld_busy   (ld_busy),
      .ld_err    (ld_err),
      .ld_count  (ld_count),
      .req_valid (req_valid),
      .req_pc    (req_pc),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_instr (rsp_instr),
      .rsp_fault (rsp_fault),
      .rsp_ready (rsp_ready)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] instr;
      logic        fault;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] model_mem [DEPTH];
   int          model_cnt = 0;
   logic        acc_prev = 1'b0;
   int          vec_cnt = 0;
   int          err_cnt = 0;
   logic [31:0] words [4];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp) else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic exp_t expect_for(input logic [31:0] pc);
      exp_t        e;
      logic [29:0] idx;
      idx     = pc[31:2];
      e.fault = (idx >= 30'(DEPTH));
`ifdef IMEM_MISALIGN_TRAP_EN
      if (pc[1:0] != 2'b00) e.fault = 1'b1;
`endif
      e.instr = e.fault ? NOP : model_mem[idx[5:0]];
      return e;
   endfunction

   // One clock: sample handshakes mid-cycle, then advance to just after the rising edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (reset_n) begin
         if (rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
               chk("sb_unexpected_rsp", 32'(rsp_valid), 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("sb_instr", rsp_instr, e.instr);
               chk("sb_fault", 32'(rsp_fault), 32'(e.fault));
            end
         end
         if (acc_prev) chk("latency_1cyc", 32'(rsp_valid), 32'd1);
         acc_prev = req_valid && req_ready;
         if (req_valid && req_ready) exp_q.push_back(expect_for(req_pc));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic ld_write(input logic [5:0] a, input logic [31:0] d);
      ld_valid = 1'b1;
      ld_addr  = a;
      ld_data  = d;
      if (model_cnt < int'(DEPTH)) begin
         model_mem[a] = d;
         model_cnt++;
      end
      tick();
      ld_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
      chk({tag, "_req_ready"}, 32'(req_ready), 32'd0);
      chk({tag, "_ld_busy"},   32'(ld_busy),   32'd0);
      chk({tag, "_ld_err"},    32'(ld_err),    32'd0);
      chk({tag, "_rsp_fault"}, 32'(rsp_fault), 32'd0);
      chk({tag, "_ld_count"},  32'(ld_count),  32'd0);
      chk({tag, "_rsp_instr"}, rsp_instr,      NOP);
   endtask

   initial begin
      words[0] = 32'h0094_0333;
      words[1] = 32'h8001_00b3;
      words[2] = 32'h0020_9133;
      words[3] = 32'h00c5_4ab3;

      // Reset values
      #1 reset_n = 1'b0;
      #2 check_reset_outputs("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Load four words; the last write shares its cycle with ld_done
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      model_cnt = 0;
      chk("load_busy", 32'(ld_busy), 32'd1);
      chk("load_cnt0", 32'(ld_count), 32'd0);
      for (int i = 0; i < 3; i++) ld_write(6'(i), words[i]);
      ld_done = 1'b1;
      ld_write(6'd3, words[3]);
      ld_done = 1'b0;
      chk("load_cnt4", 32'(ld_count), 32'd4);
      chk("run_not_busy", 32'(ld_busy), 32'd0);
      chk("run_req_ready", 32'(req_ready), 32'd1);

      // Back-to-back fetches at pc 0,4,8,12
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      for (int k = 0; k < 4; k++) begin
         req_pc = 32'(4 * k);
         chk("b2b_req_ready", 32'(req_ready), 32'd1);
         tick();
      end
      req_valid = 1'b0;
      tick();
      chk("rsp_valid_clears", 32'(rsp_valid), 32'd0);

      // Response backpressure for three cycles
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc    = 32'd8;
      tick();
      req_pc = 32'd12;
      for (int k = 0; k < 3; k++) begin
         chk("stall_req_ready", 32'(req_ready), 32'd0);
         chk("stall_rsp_valid", 32'(rsp_valid), 32'd1);
         chk("stall_rsp_instr", rsp_instr, words[2]);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      tick();
      chk("stall_released", 32'(rsp_valid), 32'd0);

      // Out-of-range and low-bit PCs; ld_valid outside LOAD is ignored
      req_valid = 1'b1;
      req_pc    = 32'(4 * DEPTH);
      tick();
      req_pc = 32'h0000_0006;
      tick();
      req_valid = 1'b0;
      ld_valid  = 1'b1;
      ld_addr   = 6'd2;
      ld_data   = 32'hDEAD_BEEF;
      tick();
      ld_valid = 1'b0;
      chk("fault_keeps_run", 32'(req_ready), 32'd1);
      chk("fault_not_busy", 32'(ld_busy), 32'd0);
      req_valid = 1'b1;
      req_pc    = 32'd8;
      tick();
      req_valid = 1'b0;
      tick();

      // ld_start is not taken while a response is pending
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc    = 32'd0;
      tick();
      req_valid = 1'b0;
      ld_start  = 1'b1;
      tick();
      chk("ld_start_blocked", 32'(ld_busy), 32'd0);
      rsp_ready = 1'b1;
      tick();
      tick();
      ld_start  = 1'b0;
      model_cnt = 0;
      chk("reload_busy", 32'(ld_busy), 32'd1);
      chk("reload_cnt_clear", 32'(ld_count), 32'd0);

      // Overflow: DEPTH+1 writes, the last one dropped
      for (int i = 0; i < int'(DEPTH); i++) ld_write(6'(i), 32'hA000_0000 + 32'(i));
      chk("full_cnt", 32'(ld_count), 32'(DEPTH));
      chk("full_no_err", 32'(ld_err), 32'd0);
      ld_write(6'd0, 32'h5555_5555);
      chk("ovf_cnt_sat", 32'(ld_count), 32'(DEPTH));
      chk("ovf_err", 32'(ld_err), 32'd1);
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      chk("ovf_err_sticky", 32'(ld_err), 32'd1);
      req_valid = 1'b1;
      req_pc    = 32'd0;
      tick();
      req_pc = 32'(4 * (DEPTH - 1));
      tick();
      req_valid = 1'b0;
      tick();
      ld_start = 1'b1;
      tick();
      ld_start  = 1'b0;
      model_cnt = 0;
      chk("restart_err_clear", 32'(ld_err), 32'd0);
      chk("restart_cnt_clear", 32'(ld_count), 32'd0);

      // Asynchronous reset in the middle of LOAD
      ld_write(6'd1, 32'h1111_1111);
      chk("midload_cnt", 32'(ld_count), 32'd1);
      reset_n = 1'b0;
      #1 check_reset_outputs("async_rst_load");
      exp_q.delete();
      acc_prev = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Reload with no writes, then reset with a response pending
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_done  = 1'b1;
      tick();
      ld_done   = 1'b0;
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_pc    = 32'd0;
      tick();
      req_valid = 1'b0;
      chk("pending_before_rst", 32'(rsp_valid), 32'd1);
      reset_n = 1'b0;
      #1 check_reset_outputs("async_rst_pending");
      exp_q.delete();
      acc_prev = 1'b0;
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Array contents survive reset
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
      ld_done  = 1'b1;
      tick();
      ld_done   = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 1'b1;
      req_pc    = 32'd0;
      tick();
      req_pc = 32'd4;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      chk("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
